// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and helpers for the decoder scan controller.
// Channel-mask helpers serve both builds (with and without SCAN_MASK_EN);
// the default build passes an all-ones mask.
package decoder_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Lowest enabled channel: start point of a pass and the wrap target.
  function automatic logic [ADDR_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = ADDR_W'(i);
    end
    return r;
  endfunction

  // True when an enabled channel exists above the current one.
  function automatic logic has_higher(input logic [NUM_CH-1:0] m, input logic [ADDR_W-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i > int'(a) && m[i]) r = 1'b1;
    end
    return r;
  endfunction

  // Next enabled channel above the current one, else wrap to the lowest.
  function automatic logic [ADDR_W-1:0] next_ch(input logic [NUM_CH-1:0] m, input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = lowest_ch(m);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i > int'(a) && m[i]) r = ADDR_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Handshake and decoder-drive bundle of the scan controller.
// SCAN_MASK_EN adds the channel mask input.
interface decoder_scan_ctrl_if
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [DWELL_W-1:0] dwell;
`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0]  mask;
`endif
  logic [ADDR_W-1:0]  A;
  logic               E;
  logic               busy;
  logic               done;
  logic               sel_strobe;

  modport master (
`ifdef SCAN_MASK_EN
    output mask,
`endif
    output start, stop, continuous, dwell,
    input  A, E, busy, done, sel_strobe
  );

  modport slave (
`ifdef SCAN_MASK_EN
    input  mask,
`endif
    input  start, stop, continuous, dwell,
    output A, E, busy, done, sel_strobe
  );
endinterface

// File: rtl/decoder_scan_ctrl_dwell_timer.sv
// Loadable down-counter shared between dwell and blanking intervals.
// expire is high on the last cycle of the loaded interval.
module scan_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);
  logic [W-1:0] cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end

  assign expire = (cnt == W'(1));
endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 3x8 decoder: walks A through the channels with E high
// for a dwell period and E low for BLANK_CYC cycles between channels.
// Optional SCAN_MASK_EN: skip channels whose mask bit is clear.
// The FSM runs one cycle ahead of the registered outputs; stop is applied
// directly to the output register so E/busy drop on the next cycle.
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_scan_ctrl_if.slave   bus
);
  localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;

  state_t              state_p0, state_d;
  logic [ADDR_W-1:0]   addr_p0, addr_d;
  logic                first_p0, first_d;
  logic [DWELL_W-1:0]  dwell_p0, dwell_d, dwell_eff;
  logic [NUM_CH-1:0]   mask_p0, mask_d, mask_in;
  logic                tmr_load, tmr_expire;
  logic [CNT_W-1:0]    tmr_value;
  logic [ADDR_W-1:0]   addr_p1;
  logic                en_p1, busy_p1, done_p1, strobe_p1;

`ifdef SCAN_MASK_EN
  assign mask_in = bus.mask;
`else
  assign mask_in = '1;
`endif

  assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

  scan_dwell_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  // State, address and latched configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      addr_p0  <= '0;
      first_p0 <= 1'b0;
      dwell_p0 <= '0;
      mask_p0  <= '0;
    end else begin
      state_p0 <= state_d;
      addr_p0  <= addr_d;
      first_p0 <= first_d;
      dwell_p0 <= dwell_d;
      mask_p0  <= mask_d;
    end
  end

  // Next-state logic and timer control.
  always_comb begin
    state_d   = state_p0;
    addr_d    = addr_p0;
    first_d   = 1'b0;
    dwell_d   = dwell_p0;
    mask_d    = mask_p0;
    tmr_load  = 1'b0;
    tmr_value = CNT_W'(dwell_p0);
    case (state_p0)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          dwell_d = dwell_eff;
          mask_d  = mask_in;
          if (mask_in == '0) begin
            state_d = DONE;
          end else begin
            state_d   = ACTIVE;
            addr_d    = lowest_ch(mask_in);
            first_d   = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(dwell_eff);
          end
        end
      end
      ACTIVE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (tmr_expire) begin
          if (has_higher(mask_p0, addr_p0) || bus.continuous) begin
            state_d   = BLANK;
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(BLANK_CYC);
          end else begin
            state_d = DONE;
          end
        end
      end
      BLANK: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (tmr_expire) begin
          state_d   = ACTIVE;
          addr_d    = next_ch(mask_p0, addr_p0);
          first_d   = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(dwell_p0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- output stage: registered decoder drive and handshake ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p1   <= '0;
      en_p1     <= 1'b0;
      busy_p1   <= 1'b0;
      done_p1   <= 1'b0;
      strobe_p1 <= 1'b0;
    end else begin
      addr_p1 <= addr_p0;
      if (bus.stop && state_p0 != IDLE) begin
        en_p1     <= 1'b0;
        busy_p1   <= 1'b0;
        done_p1   <= 1'b0;
        strobe_p1 <= 1'b0;
      end else begin
        en_p1     <= (state_p0 == ACTIVE);
        busy_p1   <= (state_p0 == ACTIVE) || (state_p0 == BLANK);
        done_p1   <= (state_p0 == DONE);
        strobe_p1 <= first_p0;
      end
    end
  end

  assign bus.A          = addr_p1;
  assign bus.E          = en_p1;
  assign bus.busy       = busy_p1;
  assign bus.done       = done_p1;
  assign bus.sel_strobe = strobe_p1;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl driving a behavioural 3x8 decoder.
// Mask scenarios are compiled in when SCAN_MASK_EN is defined.
module tb_decoder_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  decoder_scan_ctrl_if #(.DWELL_W(8)) bus ();

  decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 3x8 decoder fed by the controller
  logic [7:0] D;
  assign D = bus.E ? (8'd1 << bus.A) : 8'd0;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pass over all 8 channels: d cycles active, then a 1-cycle blank.
  task automatic scan_pass(input int d, input bit tail_blank, input int drop_ch);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < d; j++) begin
        if (k == drop_ch && j == 0) bus.continuous = 1'b0;
        tick();
        chk("act_A", bus.A, k);
        chk("act_E", bus.E, 1);
        chk("act_busy", bus.busy, 1);
        chk("act_strobe", bus.sel_strobe, (j == 0));
        chk("act_done", bus.done, 0);
        chk("act_D", D, 32'(8'd1 << k));
      end
      if (k < 7 || tail_blank) begin
        tick();
        chk("blank_A", bus.A, k);
        chk("blank_E", bus.E, 0);
        chk("blank_busy", bus.busy, 1);
        chk("blank_strobe", bus.sel_strobe, 0);
        chk("blank_D", D, 0);
      end
    end
  endtask

  task automatic check_done_cycle(input string tag);
    tick();
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_E"}, bus.E, 0);
    chk({tag, "_A"}, bus.A, 7);
    tick();
    chk({tag, "_done_end"}, bus.done, 0);
    chk({tag, "_busy_end"}, bus.busy, 0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("lat_E", bus.E, 0);
    chk("lat_busy", bus.busy, 0);
  endtask

  initial begin
    int n_done;
    int n_en;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.continuous = 1'b0;
    bus.dwell      = 8'd3;
`ifdef SCAN_MASK_EN
    bus.mask       = 8'hFF;
`endif
    repeat (3) tick();
    chk("rst_A", bus.A, 0);
    chk("rst_E", bus.E, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_strobe", bus.sel_strobe, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single pass, dwell 3: E cycles 1-3 on ch0, ch7 on 29-31, done at 32
    bus.dwell = 8'd3;
    pulse_start();
    scan_pass(3, 1'b0, -1);
    check_done_cycle("single");

    // Continuous, dwell 2; dwell change mid-scan ignored; drop continuous in pass 2 ch3
    bus.dwell      = 8'd2;
    bus.continuous = 1'b1;
    pulse_start();
    bus.dwell = 8'd9;
    scan_pass(2, 1'b1, -1);
    scan_pass(2, 1'b0, 3);
    check_done_cycle("cont");

    // Abort during ch2, with an ignored start during ch0
    repeat (2) tick();
    bus.dwell = 8'd2;
    pulse_start();
    tick();
    chk("ab_c1_E", bus.E, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ab_c2_A", bus.A, 0);
    chk("ab_c2_E", bus.E, 1);
    repeat (2) tick();
    chk("ab_c4_A", bus.A, 1);
    chk("ab_c4_E", bus.E, 1);
    chk("ab_c4_strobe", bus.sel_strobe, 1);
    repeat (3) tick();
    chk("ab_c7_A", bus.A, 2);
    chk("ab_c7_E", bus.E, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("ab_stop_E", bus.E, 0);
    chk("ab_stop_busy", bus.busy, 0);
    chk("ab_stop_A", bus.A, 2);
    n_done = 0;
    n_en   = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done) n_done++;
      if (bus.E || bus.busy) n_en++;
    end
    chk("ab_no_done", n_done, 0);
    chk("ab_stays_idle", n_en, 0);

    // start and stop together in IDLE: stop wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick();
    chk("ss_busy1", bus.busy, 0);
    tick();
    chk("ss_busy2", bus.busy, 0);
    chk("ss_E2", bus.E, 0);

    // dwell 0 behaves as dwell 1: 15 busy cycles then done
    bus.dwell = 8'd0;
    pulse_start();
    scan_pass(1, 1'b0, -1);
    check_done_cycle("dw0");

    // Asynchronous reset mid-scan
    bus.dwell = 8'd3;
    pulse_start();
    repeat (5) tick();
    chk("pre_rst_A", bus.A, 1);
    chk("pre_rst_E", bus.E, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_A", bus.A, 0);
    chk("arst_E", bus.E, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", bus.busy, 0);

`ifdef SCAN_MASK_EN
    // Mask 1010_0100, dwell 1: ch2 @1, blank @2, ch5 @3, blank @4, ch7 @5, done @6
    bus.mask  = 8'b1010_0100;
    bus.dwell = 8'd1;
    pulse_start();
    tick(); chk("m_c1_A", bus.A, 2); chk("m_c1_E", bus.E, 1);
    tick(); chk("m_c2_A", bus.A, 2); chk("m_c2_E", bus.E, 0);
    tick(); chk("m_c3_A", bus.A, 5); chk("m_c3_E", bus.E, 1);
    tick(); chk("m_c4_A", bus.A, 5); chk("m_c4_E", bus.E, 0);
    tick(); chk("m_c5_A", bus.A, 7); chk("m_c5_E", bus.E, 1);
    tick(); chk("m_c6_done", bus.done, 1); chk("m_c6_E", bus.E, 0);
    repeat (2) tick();
    // mask 0: done one cycle after start, E never asserted
    bus.mask = 8'h00;
    pulse_start();
    tick();
    chk("m0_done", bus.done, 1);
    chk("m0_E", bus.E, 0);
    chk("m0_busy", bus.busy, 0);
    tick();
    chk("m0_done_end", bus.done, 0);
    bus.mask = 8'hFF;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
